// File: rtl/ble_crc24_append.sv
// BLE CRC-24 appender: echoes the serial air bitstream with one cycle of latency
// and, after the final PDU bit, emits the 24-bit CRC MSB-first at CLK_PER_BIT spacing.
// The preamble and access address (PREFIX_BITS) bypass the CRC.
module ble_crc24_append #(
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int CLK_PER_BIT         = 16,
  parameter int PREFIX_BITS         = 40
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic                           crc_state_init_bit_load,
  input  logic                           info_bit,
  input  logic                           info_bit_valid,
  input  logic                           info_bit_valid_last,
  output logic                           info_bit_after_crc24,
  output logic                           info_bit_after_crc24_valid,
  output logic                           info_bit_after_crc24_valid_last
);

  localparam int W       = CRC_STATE_BIT_WIDTH;
  localparam int CNT_MAX = (PREFIX_BITS > W) ? PREFIX_BITS : W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  // x^24+x^10+x^9+x^6+x^4+x^3+x+1 without the implicit x^24 term
  localparam logic [W-1:0] POLY_TAPS = W'(24'h00065B);
  localparam logic [W-1:0] INIT_RST  = W'(24'h555555);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFIX,
    S_PDU,
    S_CRC_OUT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_init_shadow;
  logic [W-1:0]       r_lfsr;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMR_W-1:0]   r_tmr;
  logic               w_in_accept;
  logic               w_crc_tick;
  logic               w_crc_done;
  logic               w_enter_crc;

  // One Galois-form LFSR step: feedback is the incoming bit against the MSB.
  function automatic logic [W-1:0] crc_step(input logic [W-1:0] s, input logic b);
    logic fb;
    fb       = b ^ s[W-1];
    crc_step = {s[W-2:0], 1'b0} ^ (fb ? POLY_TAPS : '0);
  endfunction

  assign w_in_accept = info_bit_valid && (r_state != S_CRC_OUT);
  assign w_crc_tick  = (r_state == S_CRC_OUT) && (r_tmr == '0);
  assign w_crc_done  = w_crc_tick && (r_cnt == CNT_W'(W - 1));
  assign w_enter_crc = (r_state != S_CRC_OUT) && (w_state_nxt == S_CRC_OUT);

  // Next-state logic; a flagged last bit closes the packet from any receive state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (info_bit_valid) begin
          if (info_bit_valid_last)   w_state_nxt = S_CRC_OUT;
          else if (PREFIX_BITS <= 1) w_state_nxt = S_PDU;
          else                       w_state_nxt = S_PREFIX;
        end
      end
      S_PREFIX: begin
        if (info_bit_valid) begin
          if (info_bit_valid_last)                        w_state_nxt = S_CRC_OUT;
          else if (r_cnt == CNT_W'(PREFIX_BITS - 1))      w_state_nxt = S_PDU;
        end
      end
      S_PDU: begin
        if (info_bit_valid && info_bit_valid_last) w_state_nxt = S_CRC_OUT;
      end
      S_CRC_OUT: begin
        if (w_crc_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Init shadow: may be reloaded at any time, only consumed at packet start.
  always_ff @(posedge clk) begin
    if (rst)                          r_init_shadow <= INIT_RST;
    else if (crc_state_init_bit_load) r_init_shadow <= crc_state_init_bit;
  end

  // Working LFSR, prefix/CRC bit counter and CRC bit-spacing timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= '0;
      r_cnt  <= '0;
      r_tmr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (info_bit_valid) begin
            r_lfsr <= r_init_shadow;
            r_cnt  <= CNT_W'(1);
          end
        end
        S_PREFIX: begin
          if (info_bit_valid) r_cnt <= r_cnt + CNT_W'(1);
        end
        S_PDU: begin
          if (info_bit_valid) r_lfsr <= crc_step(r_lfsr, info_bit);
        end
        S_CRC_OUT: begin
          if (w_crc_tick) begin
            r_lfsr <= {r_lfsr[W-2:0], 1'b0};
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tmr  <= TMR_W'(CLK_PER_BIT - 1);
          end else begin
            r_tmr  <= r_tmr - TMR_W'(1);
          end
        end
        default: ;
      endcase
      if (w_enter_crc) begin
        r_cnt <= '0;
        r_tmr <= TMR_W'(CLK_PER_BIT - 1);
      end
    end
  end

  // Registered output: echoed input bit or next CRC bit, zero when not strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      info_bit_after_crc24            <= 1'b0;
      info_bit_after_crc24_valid      <= 1'b0;
      info_bit_after_crc24_valid_last <= 1'b0;
    end else begin
      info_bit_after_crc24            <= 1'b0;
      info_bit_after_crc24_valid      <= 1'b0;
      info_bit_after_crc24_valid_last <= 1'b0;
      if (w_in_accept) begin
        info_bit_after_crc24       <= info_bit;
        info_bit_after_crc24_valid <= 1'b1;
      end else if (w_crc_tick) begin
        info_bit_after_crc24            <= r_lfsr[W-1];
        info_bit_after_crc24_valid      <= 1'b1;
        info_bit_after_crc24_valid_last <= w_crc_done;
      end
    end
  end

endmodule

// File: tb/tb_ble_crc24_append.sv
// Bench for ble_crc24_append: directed packets, expected output bits queued as
// stimulus is driven and checked against each output strobe.
module tb_ble_crc24_append;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] crc_state_init_bit = '0;
  logic        crc_state_init_bit_load = 1'b0;
  logic        info_bit = 1'b0;
  logic        info_bit_valid = 1'b0;
  logic        info_bit_valid_last = 1'b0;
  logic        info_bit_after_crc24;
  logic        info_bit_after_crc24_valid;
  logic        info_bit_after_crc24_valid_last;

  ble_crc24_append #(
    .CRC_STATE_BIT_WIDTH(24),
    .CLK_PER_BIT(CPB),
    .PREFIX_BITS(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .crc_state_init_bit(crc_state_init_bit),
    .crc_state_init_bit_load(crc_state_init_bit_load),
    .info_bit(info_bit),
    .info_bit_valid(info_bit_valid),
    .info_bit_valid_last(info_bit_valid_last),
    .info_bit_after_crc24(info_bit_after_crc24),
    .info_bit_after_crc24_valid(info_bit_after_crc24_valid),
    .info_bit_after_crc24_valid_last(info_bit_after_crc24_valid_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic last;
    logic crc;
    int   t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prev_strobe = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference CRC: polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1, bits in air order.
  function automatic logic [23:0] crc_model(input logic [23:0] init, input logic [63:0] pdu, input int n);
    logic [23:0] s;
    logic        fb;
    s = init;
    for (int i = 0; i < n; i++) begin
      fb = pdu[i] ^ s[23];
      s  = s << 1;
      if (fb) begin
        s[0]  = ~s[0];  s[1]  = ~s[1];  s[3]  = ~s[3];  s[4] = ~s[4];
        s[6]  = ~s[6];  s[9]  = ~s[9];  s[10] = ~s[10];
      end
    end
    return s;
  endfunction

  // Output monitor: pops one expectation per strobe and checks bit, last flag and timing.
  always @(negedge clk) begin
    exp_t e;
    if (info_bit_after_crc24_valid) begin
      check("strobe_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out_bit", 32'(info_bit_after_crc24), 32'(e.b));
        check("out_last", 32'(info_bit_after_crc24_valid_last), 32'(e.last));
        if (e.crc) check("crc_spacing", 32'(cyc - prev_strobe), 32'(CPB));
        else       check("echo_latency", 32'(cyc), 32'(e.t));
      end
      prev_strobe = cyc;
    end else begin
      check("idle_bit", 32'(info_bit_after_crc24), 32'd0);
      check("idle_last", 32'(info_bit_after_crc24_valid_last), 32'd0);
    end
  end

  task automatic drive_bit(input logic b, input logic last, input logic push);
    exp_t e;
    @(negedge clk);
    info_bit            = b;
    info_bit_valid      = 1'b1;
    info_bit_valid_last = last;
    if (push) begin
      e.b = b; e.last = 1'b0; e.crc = 1'b0; e.t = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    info_bit            = 1'b0;
    info_bit_valid      = 1'b0;
    info_bit_valid_last = 1'b0;
  endtask

  task automatic load_init(input logic [23:0] v);
    @(negedge clk);
    crc_state_init_bit      = v;
    crc_state_init_bit_load = 1'b1;
    @(negedge clk);
    crc_state_init_bit_load = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    check("drain", 32'(q.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic send_packet(input logic [39:0] pre, input int npre,
                             input logic [63:0] pdu, input int npdu,
                             input logic [23:0] exp_crc,
                             input logic mid_load, input logic [23:0] mid_val,
                             input logic noise);
    exp_t e;
    for (int i = 0; i < npre; i++) begin
      drive_bit(pre[i], (npdu == 0) && (i == npre - 1), 1'b1);
      repeat (CPB - 2) @(negedge clk);
    end
    if (mid_load) load_init(mid_val);
    for (int i = 0; i < npdu; i++) begin
      drive_bit(pdu[i], i == npdu - 1, 1'b1);
      if (i != npdu - 1) repeat (CPB - 2) @(negedge clk);
    end
    for (int k = 0; k < 24; k++) begin
      e.b = exp_crc[23 - k]; e.last = (k == 23); e.crc = 1'b1; e.t = -1;
      q.push_back(e);
    end
    if (noise) begin
      repeat (3) begin
        repeat (20) @(negedge clk);
        drive_bit(1'b1, 1'b1, 1'b0);
      end
    end
    wait_drain();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pdu_r;
    // Reset
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(info_bit_after_crc24_valid), 32'd0);
    check("rst_bit", 32'(info_bit_after_crc24), 32'd0);
    check("rst_last", 32'(info_bit_after_crc24_valid_last), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Zero init, zero PDU: 56 echoes then 24 zero CRC bits
    load_init(24'h000000);
    send_packet(40'h0, 40, 64'h0, 16, 24'h000000, 1'b0, 24'h0, 1'b0);

    // Single-one PDU, known CRC; input strobes during CRC output are ignored
    send_packet(40'h0, 40, 64'h1, 16, 24'h2D8AED, 1'b0, 24'h0, 1'b1);

    // Alternating prefix does not affect the CRC
    send_packet(40'hAAAAAAAAAA, 40, 64'h1, 16, 24'h2D8AED, 1'b0, 24'h0, 1'b0);
    pdu_r = {$urandom, $urandom};
    send_packet(40'h5555555555, 40, pdu_r, 32, crc_model(24'h0, pdu_r, 32), 1'b0, 24'h0, 1'b0);

    // Last flagged inside the prefix: CRC is the untouched init value
    load_init(24'hABCDEF);
    send_packet(40'h3FF, 10, 64'h0, 0, 24'hABCDEF, 1'b0, 24'h0, 1'b0);

    // Mid-packet init load affects only the following packet
    load_init(24'h000000);
    send_packet(40'h0, 40, 64'hB3, 20, crc_model(24'h000000, 64'hB3, 20), 1'b1, 24'h123456, 1'b0);
    send_packet(40'h0, 40, 64'h1, 16, crc_model(24'h123456, 64'h1, 16), 1'b0, 24'h0, 1'b0);

    // Reset after 50 input bits aborts the packet and restores init 0x555555
    for (int i = 0; i < 50; i++) begin
      drive_bit((i == 49) ? 1'b1 : i[0], 1'b0, 1'b1);
      if (i != 49) repeat (CPB - 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(info_bit_after_crc24_valid), 32'd0);
    check("abort_bit", 32'(info_bit_after_crc24), 32'd0);
    check("abort_last", 32'(info_bit_after_crc24_valid_last), 32'd0);
    rst = 1'b0;
    check("abort_queue", 32'(q.size()), 32'd0);
    q.delete();
    repeat (500) @(negedge clk);
    send_packet(40'h0, 40, 64'hC5, 8, crc_model(24'h555555, 64'hC5, 8), 1'b0, 24'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ble_crc24_append.md
BLE_CRC24_APPEND -- requirements
Module: ble_crc24_append

Interface
REQ-001 SHALL: parameter CRC_STATE_BIT_WIDTH, default 24, sets the CRC register and init-value width.
REQ-002 SHALL: parameter CLK_PER_BIT, default 16, sets the clock spacing between appended CRC output bits.
REQ-003 SHALL: parameter PREFIX_BITS, default 40, sets the count of leading bits (preamble + access address) that bypass the CRC.
REQ-004 SHALL: clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL: rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL: crc_state_init_bit  in  CRC_STATE_BIT_WIDTH  CRC init value; bit k maps to LFSR position k.
REQ-007 SHALL: crc_state_init_bit_load  in  1  when high, captures crc_state_init_bit into the init shadow register.
REQ-008 SHALL: info_bit  in  1  serial input bit, LSB-first over-the-air order.
REQ-009 SHALL: info_bit_valid  in  1  one-cycle strobe qualifying info_bit.
REQ-010 SHALL: info_bit_valid_last  in  1  high with the final PDU bit's valid strobe.
REQ-011 SHALL: info_bit_after_crc24  out  1  pass-through bits followed by 24 CRC bits.
REQ-012 SHALL: info_bit_after_crc24_valid  out  1  one-cycle strobe qualifying the output bit.
REQ-013 SHALL: info_bit_after_crc24_valid_last  out  1  high only with the final CRC bit's strobe.

Function
REQ-014 SHALL: states are IDLE, PREFIX, PDU and CRC_OUT.
REQ-015 SHALL: on the first info_bit_valid in IDLE, copy the shadow init into the working LFSR, then enter PREFIX.
REQ-016 SHALL: forward every input bit as info_bit_after_crc24 with _valid exactly 1 cycle after info_bit_valid (latency 1).
REQ-017 SHALL: in PREFIX, forward the first PREFIX_BITS valid bits, leaving the LFSR unchanged, then enter PDU.
REQ-018 SHALL: in PDU, advance the LFSR once per valid bit, Galois form, polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1.
REQ-019 SHALL: LFSR update: fb = info_bit XOR reg[23]; reg <= reg<<1; when fb=1, XOR bits 0,1,3,4,6,9,10.
REQ-020 SHALL: a valid with info_bit_valid_last=1 (any state after IDLE) is forwarded and included in the CRC, then CRC_OUT is entered.
REQ-021 SHALL: in CRC_OUT, emit reg[23] first down to reg[0], one bit per CLK_PER_BIT clocks.
REQ-022 SHALL: the first CRC bit's strobe comes CLK_PER_BIT clocks after the last forwarded bit's strobe.
REQ-023 SHALL: assert _valid_last with the 24th CRC bit's strobe, then return to IDLE.
REQ-024 SHALL: ignore input strobes during CRC_OUT.
REQ-025 SHALL: drive the output bit 0 whenever its valid is low.
REQ-026 SHALL: when crc_state_init_bit_load rises mid-packet, update the shadow only; the working LFSR is unaffected until the next packet.
REQ-027 SHALL: info_bit_valid_last in PREFIX goes to CRC_OUT with the LFSR still equal to the init value.

Reset
REQ-028 SHALL: rst forces IDLE, clears all outputs, counters and the working LFSR, and sets the shadow init to 0x555555.
REQ-029 SHALL: rst asserted mid-packet aborts it with no further output strobes; rst takes priority over crc_state_init_bit_load.

Verification
REQ-030 SHALL: init 0x000000; 40 prefix bits + 16 zero PDU bits, strobes every 16 clk -> 56 echoed bits, then 24 zeros, last strobe on the 80th.
REQ-031 SHALL: init 0x000000; PDU = 1 followed by 15 zeros -> CRC 0x2D8AED, sent MSB first (0,0,1,0,1,1,0,1,...).
REQ-032 SHALL: alternating-1/0 prefix bits with any PDU -> CRC equals that of the PDU alone, because the prefix is excluded.
REQ-033 SHALL: rst after 50 input bits -> outputs 0 next cycle; a following packet with shadow 0x555555 produces the CRC computed from 0x555555.
REQ-034 SHALL: pulse crc_state_init_bit_load mid-packet with a new value -> current CRC unaffected; the next packet uses the new value.
REQ-035 SHALL: output strobes are checked at the transitions: CRC bit 1 comes exactly 16 clocks after the last echoed bit, and CRC bits are 16 clocks apart.
